// File: rtl/sub_operand_pairer.sv
// Pairs a byte stream into minuend/subtrahend for an external subtractor,
// captures the difference one cycle later and hands it downstream.
module sub_operand_pairer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] out_data,
  output logic             out_borrow,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       pair_count
);

  typedef enum logic [1:0] {
    S_A,
    S_B,
    S_CALC,
    S_OUT
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   in_fire;
  logic   out_fire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_A;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = S_A;
    end else begin
      unique case (state)
        S_A:    if (in_valid)  state_nxt = S_B;
        S_B:    if (in_valid)  state_nxt = S_CALC;
        S_CALC:                state_nxt = S_OUT;
        S_OUT:  if (out_ready) state_nxt = S_A;
        default:               state_nxt = S_A;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state == S_A) || (state == S_B);
    out_valid = (state == S_OUT);
  end

  // flush outranks both handshakes, so neither side may commit state
  assign in_fire  = in_valid && in_ready && !flush;
  assign out_fire = out_valid && out_ready && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a          <= '0;
      b          <= '0;
      out_data   <= '0;
      out_borrow <= 1'b0;
      pair_count <= 8'd0;
    end else begin
      if (in_fire && state == S_A) a <= in_data;
      if (in_fire && state == S_B) b <= in_data;
      // c has had a full period to settle since b was registered
      if (state == S_CALC && !flush) begin
        out_data   <= c;
        out_borrow <= (a < b);
      end
      if (out_fire) pair_count <= pair_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_sub_operand_pairer.sv
// Directed bench for sub_operand_pairer with a behavioural subtractor
// closing the a/b -> c loop.
module tb_sub_operand_pairer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic [7:0] c;
  logic [7:0] out_data;
  logic       out_borrow;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] pair_count;

  int total = 0;
  int bad = 0;
  logic [7:0] pc_m = 8'd0;

  always #5 clk = ~clk;

  assign c = a - b;

  sub_operand_pairer #(.WIDTH(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .flush(flush),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a(a),
    .b(b),
    .c(c),
    .out_data(out_data),
    .out_borrow(out_borrow),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .pair_count(pair_count)
  );

  // Offer one byte from a negedge; returns on the negedge after acceptance.
  task automatic send_byte(input logic [7:0] d, output bit ok);
    ok = 1'b0;
    in_data = d;
    in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (in_ready) begin
        ok = 1'b1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({in_ready, out_valid, out_borrow} !== 3'b100) begin
      bad++;
      $display("FAIL reset_flags: got %b want 100",
               {in_ready, out_valid, out_borrow});
    end
    total++;
    if ({a, b, out_data, pair_count} !== 32'h0) begin
      bad++;
      $display("FAIL reset_regs: got %h want 00000000",
               {a, b, out_data, pair_count});
    end
    rst_n = 1'b1;
    pc_m = 8'd0;
    @(negedge clk);
  endtask

  task automatic test_arith;
    logic [7:0] va [4] = '{8'h50, 8'h10, 8'h00, 8'hFF};
    logic [7:0] vb [4] = '{8'h20, 8'h20, 8'h00, 8'hFF};
    logic [7:0] vd [4] = '{8'h30, 8'hF0, 8'h00, 8'h00};
    logic       vw [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    bit ok;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send_byte(va[i], ok);
      send_byte(vb[i], ok);
      total++;
      if (!ok || a !== va[i] || b !== vb[i] || out_valid !== 1'b0) begin
        bad++;
        $display("FAIL arith_operands[%0d]: got a=%h b=%h ov=%b want %h %h 0",
                 i, a, b, out_valid, va[i], vb[i]);
      end
      @(negedge clk);
      total++;
      if (out_valid !== 1'b1 || out_data !== vd[i] ||
          out_borrow !== vw[i]) begin
        bad++;
        $display("FAIL arith_result[%0d]: got v=%b d=%h w=%b want 1 %h %b",
                 i, out_valid, out_data, out_borrow, vd[i], vw[i]);
      end
      @(negedge clk);
      pc_m++;
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || pair_count !== pc_m) begin
        bad++;
        $display("FAIL arith_done[%0d]: got v=%b r=%b pc=%0d want 0 1 %0d",
                 i, out_valid, in_ready, pair_count, pc_m);
      end
    end
  endtask

  task automatic test_backpressure;
    bit ok;
    out_ready = 1'b0;
    send_byte(8'h80, ok);
    send_byte(8'h01, ok);
    @(negedge clk);
    in_data = 8'hAA;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (out_valid !== 1'b1 || out_data !== 8'h7F || out_borrow !== 1'b0 ||
          in_ready !== 1'b0 || a !== 8'h80) begin
        bad++;
        $display("FAIL bp_hold[%0d]: got v=%b d=%h r=%b a=%h want 1 7f 0 80",
                 i, out_valid, out_data, in_ready, a);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    pc_m++;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || pair_count !== pc_m) begin
      bad++;
      $display("FAIL bp_release: got v=%b r=%b pc=%0d want 0 1 %0d",
               out_valid, in_ready, pair_count, pc_m);
    end
  endtask

  task automatic test_flush;
    bit ok;
    out_ready = 1'b1;
    send_byte(8'h33, ok);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || a !== 8'h33) begin
      bad++;
      $display("FAIL flush_partial: got r=%b v=%b a=%h want 1 0 33",
               in_ready, out_valid, a);
    end
    send_byte(8'h09, ok);
    send_byte(8'h04, ok);
    @(negedge clk);
    total++;
    if (out_valid !== 1'b1 || out_data !== 8'h05 || a !== 8'h09) begin
      bad++;
      $display("FAIL flush_next: got v=%b d=%h a=%h want 1 05 09",
               out_valid, out_data, a);
    end
    @(negedge clk);
    pc_m++;
    out_ready = 1'b0;
    send_byte(8'h01, ok);
    send_byte(8'h01, ok);
    @(negedge clk);
    out_ready = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    total++;
    if (out_valid !== 1'b0 || pair_count !== pc_m) begin
      bad++;
      $display("FAIL flush_vs_handshake: got v=%b pc=%0d want 0 %0d",
               out_valid, pair_count, pc_m);
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    out_ready = 1'b0;
    send_byte(8'h40, ok);
    send_byte(8'h10, ok);
    rst_n = 1'b0;
    #1;
    total++;
    if ({in_ready, out_valid, out_borrow} !== 3'b100 ||
        {a, b, out_data, pair_count} !== 32'h0) begin
      bad++;
      $display("FAIL rst_in_calc: got r=%b v=%b regs=%h want 1 0 00000000",
               in_ready, out_valid, {a, b, out_data, pair_count});
    end
    @(negedge clk);
    rst_n = 1'b1;
    pc_m = 8'd0;
    @(negedge clk);
    send_byte(8'h40, ok);
    send_byte(8'h10, ok);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 ||
        {a, b, out_data, out_borrow} !== 25'h0) begin
      bad++;
      $display("FAIL rst_in_out: got v=%b r=%b d=%h a=%h want 0 1 00 00",
               out_valid, in_ready, out_data, a);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_byte(8'h77, ok);
    total++;
    if (!ok || a !== 8'h77 || b !== 8'h00 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL rst_first_byte: got a=%h b=%h r=%b want 77 00 1",
               a, b, in_ready);
    end
    out_ready = 1'b1;
    send_byte(8'h02, ok);
    @(negedge clk);
    total++;
    if (out_valid !== 1'b1 || out_data !== 8'h75) begin
      bad++;
      $display("FAIL rst_after: got v=%b d=%h want 1 75", out_valid, out_data);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    bit ok1, ok2, ok3;
    logic [7:0] x, y;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    pc_m = 8'd0;
    out_ready = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 257; i++) begin
      x = 8'($urandom);
      y = 8'($urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send_byte(x, ok1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send_byte(y, ok2);
      wait_out(ok3);
      total++;
      if (!(ok1 && ok2 && ok3) || out_data !== 8'(x - y) ||
          out_borrow !== (x < y)) begin
        bad++;
        $display("FAIL b2b[%0d]: got d=%h w=%b want %h %b (ok=%b%b%b)",
                 i, out_data, out_borrow, 8'(x - y), x < y, ok1, ok2, ok3);
      end
      @(negedge clk);
      pc_m++;
      if (i == 255 || i == 256) begin
        total++;
        if (pair_count !== pc_m) begin
          bad++;
          $display("FAIL b2b_count[%0d]: got %0d want %0d",
                   i, pair_count, pc_m);
        end
      end
    end
  endtask

  initial begin
    test_reset;
    test_arith;
    test_backpressure;
    test_flush;
    test_reset_mid;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sub_operand_pairer.md
Name: sub_operand_pairer

Overview:
- Upstream feeder for the 8-bit combinational subtractor.
- Accepts a byte stream over a valid/ready handshake and pairs consecutive bytes into minuend (a) and subtrahend (b).
- Drives a and b from registers into the subtractor, then captures the difference c on the following cycle.
- Presents the captured result with a borrow flag on an output valid/ready handshake, and counts completed subtractions.

Parameters:
- WIDTH, 8, operand/result width. Must match the subtractor's port width.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous abort of the operation in progress.
- in_data  input  WIDTH  operand byte from upstream.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept in_data this cycle.
- a  output  WIDTH  minuend to the subtractor (registered).
- b  output  WIDTH  subtrahend to the subtractor (registered).
- c  input  WIDTH  difference returned by the subtractor (a - b, mod 2^WIDTH).
- out_data  output  WIDTH  captured difference.
- out_borrow  output  1  1 when a < b (unsigned), i.e. the difference wrapped.
- out_valid  output  1  out_data/out_borrow are valid.
- out_ready  input  1  downstream accepts the result.
- pair_count  output  8  number of results accepted downstream, mod 256.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n, and all flops use it.
- Reset values:
  - state = S_A.
  - a, b, out_data = 0.
  - out_borrow = 0, out_valid = 0, pair_count = 0.
  - in_ready = 1, because it is decoded from state. Upstream must not assert in_valid during reset.
- Decoded outputs: in_ready = (state==S_A || state==S_B); out_valid = (state==S_OUT).
- S_A: on in_valid && in_ready, latch a <= in_data and go to S_B. Otherwise hold.
- S_B: on in_valid && in_ready, latch b <= in_data and go to S_CALC. Otherwise hold; a stays stable.
- S_CALC (exactly one cycle, in_ready=0):
  - out_data <= c.
  - out_borrow <= (a < b), computed in this block from the registers, not derived from c.
  - Go to S_OUT.
- S_OUT: out_valid=1. out_data and out_borrow are held stable until out_ready. On out_ready: pair_count <= pair_count+1 and go to S_A.
- Timing:
  - c is sampled a full cycle after b is registered, so the combinational subtractor path gets one whole clock period.
  - Latency: B handshake at edge k, capture at edge k+1, out_valid high from edge k+1.
  - Minimum 4 cycles per result when out_ready is held high (A, B, CALC, OUT).
- Arithmetic: difference is modulo 2^WIDTH, e.g. 0x10-0x20 = 0xF0. pair_count wraps 255 -> 0 with no flag.
- Backpressure: while in S_OUT with out_ready=0, in_ready=0 and no new operands are accepted. There is no internal buffering beyond one result.
- flush (highest priority, synchronous):
  - Forces state to S_A and discards any partial or pending result, so out_valid drops the next cycle.
  - a, b, out_data and pair_count are left unchanged.
  - If flush coincides with an out_ready handshake in S_OUT, the flush wins and pair_count does not increment.
- Reset mid-operation: asynchronous return to all reset values regardless of state, with no partial output.
- No X propagation: out_data and out_borrow must hold defined values at all times after reset.

Test Plan:
- Reset, then feed 0x50, 0x20 with out_ready=1 -> a=0x50, b=0x20; out_data=0x30, out_borrow=0, out_valid for 1 cycle, pair_count=1.
- Feed 0x10, 0x20 -> out_data=0xF0, out_borrow=1. Feed 0x00, 0x00 -> out_data=0x00, out_borrow=0. Feed 0xFF, 0xFF -> 0x00 / 0.
- Feed 0x80, 0x01 with out_ready=0 for 5 cycles -> out_valid held, out_data=0x7F stable, in_ready=0 throughout; on out_ready, 1-cycle handshake and return to S_A.
- Feed 0x33, then flush before the second byte -> in_ready stays 1, no out_valid. Next pair 0x09, 0x04 -> out_data=0x05, and 0x33 is never used.
- Assert rst_n=0 in S_CALC and in S_OUT -> all outputs return to reset values immediately; after release the first byte is taken as a.
- Complete 257 pairs back-to-back with random in_valid gaps -> every result matches the model; pair_count reads 0 after the 256th result and 1 after the 257th.
